fft_frame_feeder: RTL
=====================

# fft_frame_feeder

AXI4-Stream master that turns a free-running real audio sample stream into complete FFT input frames for the radix-2 burst FFT wrapper (ipsxb_fft_demo_r2_1024). Samples are collected in a ping-pong buffer of two FFT_LEN banks. Each full bank is emitted as one back-pressured frame with tlast on the final beat, preceded by a one-cycle config pulse. It sits between the audio capture path and the FFT data/config slave ports.

## Interface
- LOG2_FFT_LEN, 10, log2 of frame length (FFT_LEN = 2^LOG2_FFT_LEN = 1024)
- INPUT_WIDTH, 16, sample width; 1..16
- FFT_MODE, 1'b1, value driven on cfg tdata (1 = forward FFT)
- DATAIN_WIDTH, derived, byte-rounded INPUT_WIDTH (16 by default)

- i_aclk  in  1  sole clock
- i_rst  in  1  reset, synchronous, active-high
- i_sample  in  INPUT_WIDTH  signed real sample
- i_sample_vld  in  1  sample strobe, any duty cycle
- o_axi4s_data_tvalid  out  1  frame beat valid
- o_axi4s_data_tdata  out  2*DATAIN_WIDTH  {im, re}; im = 0, re = sign-extended sample
- o_axi4s_data_tlast  out  1  high on beat FFT_LEN-1
- i_axi4s_data_tready  in  1  FFT ready
- o_axi4s_cfg_tvalid  out  1  one-cycle config pulse per frame
- o_axi4s_cfg_tdata  out  1  FFT_MODE while cfg_tvalid is high, else 0
- o_ovf  out  1  sticky: at least one sample dropped; cleared only by i_rst
- o_frame_cnt  out  16  frames fully sent, wraps at 2^16

## Operation
- Write side:
  - Counter wr_idx and bank pointer wr_bank; each i_sample_vld writes the sample to wr_bank[wr_idx] and increments wr_idx.
  - At wr_idx = FFT_LEN-1, the bank is marked full and wr_bank toggles to the other bank.
- Overflow:
  - If the target bank is full or being read, the sample is dropped, o_ovf is set, and wr_idx holds.
  - A bank freed in cycle N accepts writes from N+1. A sample arriving in cycle N is dropped.
- Read FSM:
  - IDLE: if a full bank exists, go to CFG. The oldest full bank is selected.
  - CFG: o_axi4s_cfg_tvalid = 1 for exactly one cycle; start the RAM read prefetch of index 0; go to SEND.
  - SEND: stream indices 0..FFT_LEN-1. A beat transfers when tvalid & tready. After the transfer with tlast, free the bank, increment o_frame_cnt, return to IDLE.
- While tvalid is high and tready is low, tdata and tlast are held stable and tvalid stays high. tvalid never drops mid-frame.
- Prefetch uses a 2-entry skid buffer behind the 1-cycle-latency RAM so full throughput needs no combinational path from tready to the RAM address.
- Both banks full at once: banks are served in fill order.

## Timing
- Reset values: tvalid 0, tdata 0, tlast 0, cfg_tvalid 0, cfg_tdata 0, o_ovf 0, o_frame_cnt 0. Both banks empty, wr_idx 0, wr_bank 0, FSM in IDLE. All are visible the cycle after i_rst is sampled high.
- i_rst mid-frame aborts the frame. tvalid is low the next cycle with no tlast emitted, and buffered samples are discarded.
- Last sample of a bank written in cycle N, read FSM idle: cfg_tvalid high in N+1, first tvalid high in N+3.
- With tready held high: FFT_LEN consecutive beats, no bubbles. tlast lands in cycle N+3+FFT_LEN-1.
- Back-to-back frames: one IDLE cycle, then CFG, giving 3 idle cycles between the tlast beat and the next first beat.
- Write side never stalls. Samples are accepted every cycle, subject to overflow.

## Structure
- Package fft_frame_feeder_pkg: FSM state enum (IDLE, CFG, SEND), FFT_LEN and DATAIN_WIDTH derivation functions, frame counter width constant.
- Sub-module fft_feeder_bank_ram: simple dual-port RAM, 2*FFT_LEN x INPUT_WIDTH, address {bank, idx}, 1-cycle registered read, DRM-inferable.
- Top level holds the write counter, bank status flags, read FSM, skid buffer and output registers.

## Test plan
- Reset then 1024 samples with value = index, tready = 1:
  - one cfg pulse with tdata 1
  - first beat 2 cycles later, 1024 gapless beats, re = 0..1023, im = 0
  - tlast only on beat 1023; o_frame_cnt = 1
- Random tready with 30% low: data sequence identical to the above; tdata and tlast held stable during every stall; no dropped or duplicated beat.
- Sample 0x8000 with INPUT_WIDTH = 12 (input 0x800): re field = 0xF800, sign-extended.
- tready low for 2100 sample strobes: first 2048 samples buffered, o_ovf = 1; after tready rises, exactly two frames are emitted, holding samples 0..2047.
- Sample strobe in the same cycle as the freeing tlast transfer, with the other bank full: that sample is dropped; the next sample is written to index 0 of the freed bank.
- i_rst asserted at beat 500: tvalid = 0 next cycle, all outputs at reset values; the next 1024 samples produce a clean frame starting at index 0.

Source files
------------

// File: rtl/fft_frame_feeder_pkg.sv
// Shared types and size helpers for the FFT frame feeder.
package fft_frame_feeder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CFG  = 2'd1,
        SEND = 2'd2
    } feed_state_e;

    localparam int unsigned FRAME_CNT_W = 16;

    function automatic int unsigned fft_len(input int unsigned log2_len);
        return 32'd1 << log2_len;
    endfunction

    // Sample width rounded up to whole bytes, as the FFT core expects.
    function automatic int unsigned datain_width(input int unsigned in_w);
        return ((in_w + 32'd7) / 32'd8) * 32'd8;
    endfunction

endpackage

// File: rtl/fft_feeder_bank_ram.sv
// Simple dual-port sample RAM holding both ping-pong banks; registered read.
module fft_feeder_bank_ram #(
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fft_frame_feeder.sv
// Collects audio samples into two banks and streams each full bank to the FFT
// as one AXI4-Stream frame, preceded by a single config beat.
module fft_frame_feeder
    import fft_frame_feeder_pkg::*;
#(
    parameter int unsigned  LOG2_FFT_LEN = 10,
    parameter int unsigned  INPUT_WIDTH  = 16,
    parameter logic         FFT_MODE     = 1'b1,
    localparam int unsigned DATAIN_WIDTH = datain_width(INPUT_WIDTH)
) (
    input  logic                      i_aclk,
    input  logic                      i_rst,
    input  logic [INPUT_WIDTH-1:0]    i_sample,
    input  logic                      i_sample_vld,
    output logic                      o_axi4s_data_tvalid,
    output logic [2*DATAIN_WIDTH-1:0] o_axi4s_data_tdata,
    output logic                      o_axi4s_data_tlast,
    input  logic                      i_axi4s_data_tready,
    output logic                      o_axi4s_cfg_tvalid,
    output logic                      o_axi4s_cfg_tdata,
    output logic                      o_ovf,
    output logic [FRAME_CNT_W-1:0]    o_frame_cnt
);

    localparam int unsigned FFT_LEN = fft_len(LOG2_FFT_LEN);
    localparam int unsigned ADDR_W  = LOG2_FFT_LEN + 1;
    localparam int unsigned CNT_W   = LOG2_FFT_LEN + 1;
    localparam int unsigned TD_W    = 2 * DATAIN_WIDTH;
    localparam logic [LOG2_FFT_LEN-1:0] LAST_IDX = LOG2_FFT_LEN'(FFT_LEN - 1);

    feed_state_e state, state_next;

    logic [LOG2_FFT_LEN-1:0] wr_idx;
    logic                    wr_bank;
    logic [1:0]              bank_full;
    logic                    rd_bank;
    logic [CNT_W-1:0]        rd_cnt;
    logic                    ram_vld;
    logic                    ram_last;
    logic [INPUT_WIDTH-1:0]  ram_q;
    logic [INPUT_WIDTH-1:0]  sk_data [2];
    logic                    sk_last [2];
    logic [1:0]              sk_cnt;

    logic       wr_en_c, wr_fill_c, bank_ready_c, rd_en_c;
    logic       beat_xfer_c, frame_done_c, out_load_c;
    logic [1:0] set_mask_c, clr_mask_c;

    // Real sample becomes {im = 0, re = sign-extended sample}.
    function automatic logic [TD_W-1:0] pack_beat(input logic [INPUT_WIDTH-1:0] s);
        logic signed [DATAIN_WIDTH-1:0] re;
        re = DATAIN_WIDTH'($signed(s));
        return {{DATAIN_WIDTH{1'b0}}, re};
    endfunction

    assign wr_en_c      = i_sample_vld && !bank_full[wr_bank];
    assign wr_fill_c    = wr_en_c && (wr_idx == LAST_IDX);
    assign beat_xfer_c  = o_axi4s_data_tvalid && i_axi4s_data_tready;
    assign frame_done_c = beat_xfer_c && o_axi4s_data_tlast;
    assign out_load_c   = !o_axi4s_data_tvalid || i_axi4s_data_tready;
    assign set_mask_c   = wr_fill_c ? (wr_bank ? 2'b10 : 2'b01) : 2'b00;
    assign clr_mask_c   = frame_done_c ? (rd_bank ? 2'b10 : 2'b01) : 2'b00;
    // Looking at the completing write lets the config pulse follow the last sample directly.
    assign bank_ready_c = bank_full[rd_bank] || (wr_fill_c && (wr_bank == rd_bank));
    // Read credit uses registered occupancy only, so tready never reaches the RAM address.
    assign rd_en_c      = (state != IDLE) && !rd_cnt[LOG2_FFT_LEN] &&
                          ((3'(sk_cnt) + 3'(o_axi4s_data_tvalid) + 3'(ram_vld)) <= 3'd2);

    fft_feeder_bank_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (INPUT_WIDTH)
    ) u_ram (
        .clk     (i_aclk),
        .wr_en   (wr_en_c),
        .wr_addr ({wr_bank, wr_idx}),
        .wr_data (i_sample),
        .rd_en   (rd_en_c),
        .rd_addr ({rd_bank, rd_cnt[LOG2_FFT_LEN-1:0]}),
        .rd_data (ram_q)
    );

    // Write side: fill counter, bank toggle, full flags and sticky overflow.
    always_ff @(posedge i_aclk) begin
        if (i_rst) begin
            wr_idx    <= '0;
            wr_bank   <= 1'b0;
            bank_full <= 2'b00;
            o_ovf     <= 1'b0;
        end else begin
            if (wr_en_c) begin
                wr_idx <= wr_fill_c ? '0 : wr_idx + LOG2_FFT_LEN'(1);
                if (wr_fill_c) begin
                    wr_bank <= ~wr_bank;
                end
            end
            if (i_sample_vld && bank_full[wr_bank]) begin
                o_ovf <= 1'b1;
            end
            bank_full <= (bank_full | set_mask_c) & ~clr_mask_c;
        end
    end

    always_ff @(posedge i_aclk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bank_ready_c) state_next = CFG;
            CFG:     state_next = SEND;
            SEND:    if (frame_done_c) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Read control: config pulse, RAM read issue, bank release and frame count.
    always_ff @(posedge i_aclk) begin
        if (i_rst) begin
            o_axi4s_cfg_tvalid <= 1'b0;
            o_axi4s_cfg_tdata  <= 1'b0;
            rd_bank            <= 1'b0;
            rd_cnt             <= '0;
            ram_vld            <= 1'b0;
            ram_last           <= 1'b0;
            o_frame_cnt        <= '0;
        end else begin
            o_axi4s_cfg_tvalid <= (state_next == CFG);
            o_axi4s_cfg_tdata  <= (state_next == CFG) ? FFT_MODE : 1'b0;
            ram_vld            <= rd_en_c;
            ram_last           <= rd_en_c && (rd_cnt[LOG2_FFT_LEN-1:0] == LAST_IDX);
            if (state == IDLE) begin
                rd_cnt <= '0;
            end else if (rd_en_c) begin
                rd_cnt <= rd_cnt + CNT_W'(1);
            end
            if (frame_done_c) begin
                rd_bank     <= ~rd_bank;
                o_frame_cnt <= o_frame_cnt + FRAME_CNT_W'(1);
            end
        end
    end

    // Output register fed in order from the skid entries, then the RAM read port.
    always_ff @(posedge i_aclk) begin
        if (i_rst) begin
            o_axi4s_data_tvalid <= 1'b0;
            o_axi4s_data_tdata  <= '0;
            o_axi4s_data_tlast  <= 1'b0;
            sk_cnt              <= 2'd0;
            sk_data[0]          <= '0;
            sk_data[1]          <= '0;
            sk_last[0]          <= 1'b0;
            sk_last[1]          <= 1'b0;
        end else if (out_load_c) begin
            if (sk_cnt != 2'd0) begin
                o_axi4s_data_tvalid <= 1'b1;
                o_axi4s_data_tdata  <= pack_beat(sk_data[0]);
                o_axi4s_data_tlast  <= sk_last[0];
                sk_data[0]          <= sk_data[1];
                sk_last[0]          <= sk_last[1];
                if (ram_vld) begin
                    if (sk_cnt == 2'd1) begin
                        sk_data[0] <= ram_q;
                        sk_last[0] <= ram_last;
                    end else begin
                        sk_data[1] <= ram_q;
                        sk_last[1] <= ram_last;
                    end
                end
                sk_cnt <= sk_cnt - 2'd1 + {1'b0, ram_vld};
            end else if (ram_vld) begin
                o_axi4s_data_tvalid <= 1'b1;
                o_axi4s_data_tdata  <= pack_beat(ram_q);
                o_axi4s_data_tlast  <= ram_last;
            end else begin
                o_axi4s_data_tvalid <= 1'b0;
                o_axi4s_data_tlast  <= 1'b0;
            end
        end else if (ram_vld) begin
            if (sk_cnt == 2'd0) begin
                sk_data[0] <= ram_q;
                sk_last[0] <= ram_last;
            end else begin
                sk_data[1] <= ram_q;
                sk_last[1] <= ram_last;
            end
            sk_cnt <= sk_cnt + 2'd1;
        end
    end

endmodule
